timer_tick_master: RTL and testbench

- Avalon-MM initiator that programs and services the 16-bit-register interval timer slave in the Nios subsystem.
- On request it writes the timer period and control registers and starts the timer in continuous mode with IRQ enabled.
- On each timer IRQ it clears the timer status and increments a tick counter.
- On request it captures a counter snapshot, reads it back, and presents it as a 32-bit value. This lets fabric logic own a timer without CPU involvement.

---
 rtl/timer_regs_pkg.sv | 42 ++++
 rtl/timer_tick_master.sv | 197 +++++++++++++++++++
 tb/tb_timer_tick_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_regs_pkg.sv
// Register map, control bit positions and FSM encoding shared by the
// timer tick master and anything else that talks to the interval timer.
package timer_regs_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;
  localparam logic [2:0] TMR_SNAPL   = 3'd4;
  localparam logic [2:0] TMR_SNAPH   = 3'd5;

  localparam int unsigned ITO   = 0;
  localparam int unsigned CONT  = 1;
  localparam int unsigned START = 2;
  localparam int unsigned STOP  = 3;

  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtrl,
    StRun,
    StClrSt,
    StWrSnap,
    StRdSl,
    StRdSh,
    StRdDone,
    StWrStop
  } tmr_state_e;

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w        = '0;
    w[ITO]   = ito;
    w[CONT]  = cont;
    w[START] = start;
    w[STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/timer_tick_master.sv
// Avalon-MM initiator that programs the interval timer, counts its timeouts and
// reads back counter snapshots, with every bus output driven from a register.
module timer_tick_master
  import timer_regs_pkg::*;
#(
  parameter int unsigned TICK_W       = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period_in,
  input  logic              snap_req,
  output logic              busy,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              timer_irq
);

  tmr_state_e        r_state, w_state_next;
  logic [31:0]       r_period, w_period_next;
  logic [TICK_W-1:0] r_tick, w_tick_next;
  logic              r_stop_pend, w_stop_pend_next;
  logic              r_snap_pend, w_snap_pend_next;
  logic [15:0]       r_snap_lo, w_snap_lo_next;
  logic [31:0]       r_snap_value, w_snap_value_next;
  logic              r_snap_valid, w_snap_valid_next;
  logic              r_cs, w_cs_next;
  logic              r_wn, w_wn_next;
  logic [2:0]        r_addr, w_addr_next;
  logic [15:0]       r_wdata, w_wdata_next;
  logic              w_active;
  logic              w_stop_now;
  logic              w_snap_now;

  assign w_active   = (r_state != StIdle);
  // A pulse arriving in the same cycle as the RUN decision counts as pending.
  assign w_stop_now = r_stop_pend | stop;
  assign w_snap_now = r_snap_pend | snap_req;

  always_comb begin
    w_state_next      = r_state;
    w_period_next     = r_period;
    w_tick_next       = r_tick;
    w_stop_pend_next  = r_stop_pend | (stop & w_active);
    w_snap_pend_next  = r_snap_pend | (snap_req & w_active);
    w_snap_lo_next    = r_snap_lo;
    w_snap_value_next = r_snap_value;
    w_snap_valid_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next  = StWrPl;
          w_period_next = (period_in == 32'd0) ? RESET_PERIOD : period_in;
          w_tick_next   = '0;
        end
      end
      StWrPl:   w_state_next = StWrPh;
      StWrPh:   w_state_next = StWrCtrl;
      StWrCtrl: w_state_next = StRun;
      StRun: begin
        if (w_stop_now) begin
          w_state_next = StWrStop;
        end else if (timer_irq) begin
          w_state_next = StClrSt;
        end else if (w_snap_now) begin
          w_state_next = StWrSnap;
        end
      end
      StClrSt: begin
        w_tick_next  = r_tick + TICK_W'(1);
        w_state_next = StRun;
      end
      StWrSnap: w_state_next = StRdSl;
      StRdSl:   w_state_next = StRdSh;
      StRdSh: begin
        // Slave read data lags the address by one cycle: this is the SNAPL word.
        w_snap_lo_next = m_readdata;
        w_state_next   = StRdDone;
      end
      StRdDone: begin
        w_snap_value_next = {m_readdata, r_snap_lo};
        w_snap_valid_next = 1'b1;
        w_snap_pend_next  = 1'b0;
        w_state_next      = StRun;
      end
      StWrStop: begin
        w_stop_pend_next = 1'b0;
        w_snap_pend_next = 1'b0;
        w_state_next     = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Bus cycle is decoded from the next state so it lines up with that state.
  always_comb begin
    w_cs_next    = 1'b0;
    w_wn_next    = 1'b1;
    w_addr_next  = TMR_STATUS;
    w_wdata_next = '0;
    unique case (w_state_next)
      StWrPl: begin
        w_cs_next    = 1'b1;
        w_wn_next    = 1'b0;
        w_addr_next  = TMR_PERIODL;
        w_wdata_next = w_period_next[15:0];
      end
      StWrPh: begin
        w_cs_next    = 1'b1;
        w_wn_next    = 1'b0;
        w_addr_next  = TMR_PERIODH;
        w_wdata_next = w_period_next[31:16];
      end
      StWrCtrl: begin
        w_cs_next    = 1'b1;
        w_wn_next    = 1'b0;
        w_addr_next  = TMR_CONTROL;
        w_wdata_next = ctrl_word(1'b1, 1'b1, 1'b1, 1'b0);
      end
      StClrSt: begin
        w_cs_next    = 1'b1;
        w_wn_next    = 1'b0;
        w_addr_next  = TMR_STATUS;
      end
      StWrSnap: begin
        w_cs_next    = 1'b1;
        w_wn_next    = 1'b0;
        w_addr_next  = TMR_SNAPL;
      end
      StRdSl: begin
        w_cs_next    = 1'b1;
        w_addr_next  = TMR_SNAPL;
      end
      StRdSh: begin
        w_cs_next    = 1'b1;
        w_addr_next  = TMR_SNAPH;
      end
      StWrStop: begin
        w_cs_next    = 1'b1;
        w_wn_next    = 1'b0;
        w_addr_next  = TMR_CONTROL;
        w_wdata_next = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
      end
      default: begin
        w_cs_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_period     <= '0;
      r_tick       <= '0;
      r_stop_pend  <= 1'b0;
      r_snap_pend  <= 1'b0;
      r_snap_lo    <= '0;
      r_snap_value <= '0;
      r_snap_valid <= 1'b0;
      r_cs         <= 1'b0;
      r_wn         <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_period     <= w_period_next;
      r_tick       <= w_tick_next;
      r_stop_pend  <= w_stop_pend_next;
      r_snap_pend  <= w_snap_pend_next;
      r_snap_lo    <= w_snap_lo_next;
      r_snap_value <= w_snap_value_next;
      r_snap_valid <= w_snap_valid_next;
      r_cs         <= w_cs_next;
      r_wn         <= w_wn_next;
      r_addr       <= w_addr_next;
      r_wdata      <= w_wdata_next;
    end
  end

  assign busy         = w_active;
  assign tick_count   = r_tick;
  assign snap_value   = r_snap_value;
  assign snap_valid   = r_snap_valid;
  assign m_chipselect = r_cs;
  assign m_write_n    = r_wn;
  assign m_address    = r_addr;
  assign m_writedata  = r_wdata;

endmodule

// File: tb/tb_timer_tick_master.sv
// Bench for timer_tick_master: a behavioural interval-timer slave plus a bus
// and snapshot scoreboard fed by directed stimulus.
module tb_timer_tick_master;

  localparam logic [31:0] SNAP_SRC = 32'h0001_0020;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, snap_req;
  logic [31:0] period_in;
  logic        busy;
  logic [31:0] tick_count;
  logic [31:0] snap_value;
  logic        snap_valid;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;
  logic        timer_irq;

  always #5 clk = ~clk;

  timer_tick_master #(
    .TICK_W       (32),
    .RESET_PERIOD (32'd49999)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .period_in    (period_in),
    .snap_req     (snap_req),
    .busy         (busy),
    .tick_count   (tick_count),
    .snap_value   (snap_value),
    .snap_valid   (snap_valid),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .timer_irq    (timer_irq)
  );

  // Behavioural interval timer slave.
  logic [31:0] s_period, s_cnt, s_snap;
  logic [3:0]  s_ctrl;
  logic        s_run, s_to;
  logic [15:0] s_rdata;

  assign timer_irq  = s_to & s_ctrl[0];
  assign m_readdata = s_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_period <= '0; s_cnt <= '0; s_snap <= '0; s_ctrl <= '0;
      s_run <= 1'b0; s_to <= 1'b0; s_rdata <= '0;
    end else begin
      if (s_run) begin
        if (s_cnt == 32'd0) begin
          s_cnt <= s_period;
          s_to  <= 1'b1;
        end else begin
          s_cnt <= s_cnt - 32'd1;
        end
      end
      if (m_chipselect && !m_write_n) begin
        case (m_address)
          3'd0: s_to <= 1'b0;
          3'd1: begin
            s_ctrl <= m_writedata[3:0];
            if (m_writedata[2]) begin
              s_run <= 1'b1;
              s_cnt <= s_period;
            end
            if (m_writedata[3]) s_run <= 1'b0;
          end
          3'd2: s_period[15:0]  <= m_writedata;
          3'd3: s_period[31:16] <= m_writedata;
          3'd4, 3'd5: s_snap <= SNAP_SRC;
          default: ;
        endcase
      end
      if (m_chipselect && m_write_n)
        s_rdata <= (m_address == 3'd4) ? s_snap[15:0] :
                   (m_address == 3'd5) ? s_snap[31:16] : 16'h0000;
      else
        s_rdata <= 16'h0000;
    end
  end

  typedef struct packed {
    logic        rd;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_snap[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [2:0] a, input logic [15:0] d);
    exp_bus.push_back('{rd: 1'b0, addr: a, data: d});
  endtask

  task automatic push_r(input logic [2:0] a);
    exp_bus.push_back('{rd: 1'b1, addr: a, data: 16'h0000});
  endtask

  // Monitor: every bus cycle and every snap_valid pulse must match the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_chipselect) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", {26'd0, m_write_n, m_address, 2'd0}, 32'hFFFF_FFFF);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          check("bus_rd", {31'd0, m_write_n}, {31'd0, e.rd});
          check("bus_addr", {29'd0, m_address}, {29'd0, e.addr});
          if (!e.rd) check("bus_wdata", {16'd0, m_writedata}, {16'd0, e.data});
        end
      end
      if (snap_valid) begin
        if (exp_snap.size() == 0) check("snap_unexpected", snap_value, 32'hFFFF_FFFF);
        else check("snap_value", snap_value, exp_snap.pop_front());
      end
    end
  end

  task automatic pulse_start(input logic [31:0] p);
    @(negedge clk);
    start = 1'b1;
    period_in = p;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tick(input logic [31:0] target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick_count == target) break;
    end
    check(name, tick_count, target);
  endtask

  task automatic wait_snap_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_snap.size() == 0) break;
    end
    #1;
    check("snap_drained", exp_snap.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_tick"}, tick_count, 32'd0);
    check({tag, "_snap_value"}, snap_value, 32'd0);
    check({tag, "_snap_valid"}, {31'd0, snap_valid}, 32'd0);
    check({tag, "_cs"}, {31'd0, m_chipselect}, 32'd0);
    check({tag, "_write_n"}, {31'd0, m_write_n}, 32'd1);
    check({tag, "_addr"}, {29'd0, m_address}, 32'd0);
    check({tag, "_wdata"}, {16'd0, m_writedata}, 32'd0);
  endtask

  initial begin
    logic found;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; snap_req = 1'b0; period_in = '0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Stop in IDLE is ignored: no bus cycle must appear.
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_stop_busy", {31'd0, busy}, 32'd0);

    // 1. Start with period 99: three back-to-back writes.
    push_w(3'd2, 16'h0063);
    push_w(3'd3, 16'h0000);
    push_w(3'd1, 16'h0007);
    pulse_start(32'd99);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("start_writes_done", exp_bus.size(), 0);
    check("start_busy", {31'd0, busy}, 32'd1);

    // 2. Five timeouts, each cleared and counted once.
    for (int i = 0; i < 5; i++) push_w(3'd0, 16'h0000);
    wait_tick(32'd5, 700, "tick_five");
    #1;
    check("tick_status_writes", exp_bus.size(), 0);

    // 3. Snapshot sequence.
    push_w(3'd4, 16'h0000);
    push_r(3'd4);
    push_r(3'd5);
    exp_snap.push_back(SNAP_SRC);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    wait_snap_drain(20);
    check("snap_hold", snap_value, SNAP_SRC);
    check("snap_bus_done", exp_bus.size(), 0);
    check("snap_tick", tick_count, 32'd5);

    // 4. Stop coinciding with an irq: stop wins, tick not counted.
    push_w(3'd1, 16'h0008);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timer_irq) begin
        found = 1'b1;
        break;
      end
    end
    check("irq_seen", {31'd0, found}, 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("stop_bus_done", exp_bus.size(), 0);
    check("stop_tick", tick_count, 32'd5);
    check("stop_busy", {31'd0, busy}, 32'd0);

    // 5. Zero period uses the default; second start while busy is ignored.
    //    The timeout left pending by the stop is serviced right after restart.
    push_w(3'd2, 16'hC34F);
    push_w(3'd3, 16'h0000);
    push_w(3'd1, 16'h0007);
    push_w(3'd0, 16'h0000);
    pulse_start(32'd0);
    pulse_start(32'd5);
    repeat (10) @(negedge clk);
    #1;
    check("default_bus_done", exp_bus.size(), 0);
    check("default_tick", tick_count, 32'd1);
    check("default_busy", {31'd0, busy}, 32'd1);

    // 6. Reset while the high snapshot half is being read.
    push_w(3'd4, 16'h0000);
    push_r(3'd4);
    push_r(3'd5);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_chipselect && m_write_n && m_address == 3'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rdsh_seen", {31'd0, found}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    check("midreset_bus_done", exp_bus.size(), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    push_w(3'd2, 16'h0063);
    push_w(3'd3, 16'h0000);
    push_w(3'd1, 16'h0007);
    pulse_start(32'd99);
    repeat (4) @(negedge clk);
    #1;
    check("restart_bus_done", exp_bus.size(), 0);
    push_w(3'd0, 16'h0000);
    wait_tick(32'd1, 200, "restart_tick");
    repeat (3) @(negedge clk);
    #1;
    check("restart_status_done", exp_bus.size(), 0);
    check("no_stray_snap", exp_snap.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
